// File: rtl/instr_encoder_loader.sv
// Encodes field-level instruction descriptors into 32-bit ARM words and streams them into imem.
// Defining INSTR_ENCODER_LOADER_CHECKSUM_EN adds a running XOR checksum of all written words.
module instr_encoder_loader #(
    parameter int ADDR_WIDTH = 6,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  desc_valid,
    output logic                  desc_ready,
    input  logic                  desc_last,
    input  logic [3:0]            desc_cond,
    input  logic [1:0]            desc_op,
    input  logic                  desc_mul,
    input  logic [5:0]            desc_funct,
    input  logic [3:0]            desc_rn,
    input  logic [3:0]            desc_rd,
    input  logic [11:0]           desc_src2,
    input  logic [23:0]           desc_imm24,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  cpu_run,
    output logic                  err_illegal,
    output logic                  err_overflow,
    output logic [ADDR_WIDTH:0]   word_count
`ifdef INSTR_ENCODER_LOADER_CHECKSUM_EN
    ,
    output logic [31:0]           checksum
`endif
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] BASE_PTR = ADDR_WIDTH'(BASE_ADDR % DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'((BASE_ADDR + DEPTH - 1) % DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

    state_t                state, next_state;
    logic [ADDR_WIDTH-1:0] pointer;
    logic [31:0]           enc_word;
    logic                  accept, legal, at_last_slot, session_start;

    assign accept        = desc_valid && (state == LOAD);
    assign legal         = (desc_op != 2'b11);
    assign at_last_slot  = (pointer == LAST_PTR);
    assign session_start = start && ((state == IDLE) || (state == DONE));

    always_comb begin
        enc_word = '0;
        case (desc_op)
            2'b00: enc_word = desc_mul
                ? {desc_cond, 2'b00, desc_funct, desc_rd, desc_rn, desc_src2[11:8], 4'b1001, desc_src2[3:0]}
                : {desc_cond, 2'b00, desc_funct, desc_rn, desc_rd, desc_src2};
            2'b01: enc_word = {desc_cond, 2'b01, desc_funct, desc_rn, desc_rd, desc_src2};
            2'b10: enc_word = {desc_cond, 2'b10, desc_funct[5:4], desc_imm24};
            default: enc_word = '0;
        endcase
    end

    // NOTE: every signal gets a default before the case so no path can infer a latch.
    always_comb begin
        next_state = state;
        desc_ready = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        cpu_run    = 1'b0;
        case (state)
            IDLE: if (start) next_state = LOAD;
            LOAD: begin
                desc_ready = 1'b1;
                busy       = 1'b1;
                // A last descriptor or the write into the final slot closes the session.
                if (desc_valid && (desc_last || (legal && at_last_slot))) next_state = DRAIN;
            end
            DRAIN: begin
                busy       = 1'b1;
                next_state = DONE;
            end
            DONE: begin
                done    = 1'b1;
                cpu_run = !err_illegal && !err_overflow;
                if (start) next_state = LOAD;
            end
            default: next_state = IDLE;
        endcase
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pointer      <= BASE_PTR;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= '0;
            word_count   <= '0;
            err_illegal  <= 1'b0;
            err_overflow <= 1'b0;
`ifdef INSTR_ENCODER_LOADER_CHECKSUM_EN
            checksum     <= '0;
`endif
        end else if (session_start) begin
            pointer      <= BASE_PTR;
            imem_we      <= 1'b0;
            word_count   <= '0;
            err_illegal  <= 1'b0;
            err_overflow <= 1'b0;
`ifdef INSTR_ENCODER_LOADER_CHECKSUM_EN
            checksum     <= '0;
`endif
        end else begin
            imem_we <= accept && legal;
            if (accept && legal) begin
                imem_addr  <= pointer;
                imem_wdata <= enc_word;
                pointer    <= pointer + ADDR_WIDTH'(1);
                if (at_last_slot && !desc_last) err_overflow <= 1'b1;
            end
            if (accept && !legal) err_illegal <= 1'b1;
            // Count and checksum follow the write itself, so they settle as DONE is entered.
            if (imem_we) begin
                word_count <= word_count + (ADDR_WIDTH+1)'(1);
`ifdef INSTR_ENCODER_LOADER_CHECKSUM_EN
                checksum   <= checksum ^ imem_wdata;
`endif
            end
        end
    end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Inverse of the core's instruction decode controller: encodes field-level instruction descriptors (cond/op/funct/registers/immediates) into 32-bit ARM instruction words.
- Writes the encoded words sequentially into instruction memory through a write port, then releases the CPU to run.
- Sits between the testbench or host program source and the imem write port, ahead of CPU reset release.

Parameters:
- ADDR_WIDTH, 6, word-address width of imem; capacity DEPTH = 2**ADDR_WIDTH words.
- BASE_ADDR, 0, first word address written.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse; begins a load session.
- desc_valid  in  1  descriptor valid.
- desc_ready  out  1  descriptor accepted when valid&ready at posedge.
- desc_last  in  1  marks the final descriptor of the program.
- desc_cond  in  4  condition field.
- desc_op  in  2  00 data-proc/mul, 01 memory, 10 branch, 11 illegal.
- desc_mul  in  1  with op=00, selects multiply encoding.
- desc_funct  in  6  funct field.
- desc_rn  in  4  Rn; Ra for multiply.
- desc_rd  in  4  Rd.
- desc_src2  in  12  operand2/imm12; multiply: [11:8]=Rs, [3:0]=Rm.
- desc_imm24  in  24  branch offset.
- imem_we  out  1  imem write enable.
- imem_addr  out  ADDR_WIDTH  imem word address.
- imem_wdata  out  32  encoded instruction word.
- busy  out  1  session in progress.
- done  out  1  session finished.
- cpu_run  out  1  CPU may leave reset.
- err_illegal  out  1  sticky; an op=11 descriptor was seen.
- err_overflow  out  1  sticky; capacity exhausted before desc_last.
- word_count  out  ADDR_WIDTH+1  number of words written.

Behaviour:
- Reset: all outputs 0; imem_wdata=0; state IDLE; address pointer=BASE_ADDR.
- FSM states: IDLE, LOAD, DRAIN, DONE.
- IDLE:
  - start -> LOAD.
  - On entry to LOAD, clear word_count, errors and checksum; set pointer=BASE_ADDR.
- LOAD:
  - desc_ready=1 unless a last/overflow descriptor is pending.
  - An accept at edge N is registered; imem_we=1 during cycle N+1 with imem_addr=pointer and the encoded word. Latency is 1 cycle.
  - Pointer and word_count increment after each write.
  - Back-to-back accepts give one write per cycle.
- Encoding:
  - op=00, mul=0: {cond,2'b00,funct,rn,rd,src2}.
  - op=00, mul=1: {cond,2'b00,funct,rd,rn,src2[11:8],4'b1001,src2[3:0]}.
  - op=01: {cond,2'b01,funct,rn,rd,src2}.
  - op=10: {cond,2'b10,funct[5:4],imm24}.
  - op=11: accepted, but no write and no pointer increment; err_illegal is set.
- desc_last accepted:
  - desc_ready drops from the next cycle.
  - The final write occurs in DRAIN, then the FSM goes to DONE.
  - For an illegal last descriptor, go straight to DRAIN→DONE with no write.
- Overflow:
  - The write to address BASE_ADDR+DEPTH-1 (wrap modulo DEPTH) with no desc_last pending sets err_overflow.
  - desc_ready is forced 0 and the FSM goes to DONE.
  - Pointer never wraps within a session.
- DONE:
  - done=1, busy=0.
  - cpu_run=1 only if err_illegal=0 and err_overflow=0.
  - start -> LOAD (new session; cpu_run and done cleared on entry).
- busy=1 in LOAD and DRAIN; start is ignored there.
- desc_valid in IDLE/DONE: desc_ready=0, nothing accepted.
- Asynchronous reset mid-session: immediate return to the reset state; an in-flight write is dropped (imem_we=0 immediately).

Optional Feature:
- Macro: INSTR_ENCODER_LOADER_CHECKSUM_EN.
- Defined: adds output checksum[31:0]. It is the running XOR of every written word, cleared on LOAD entry and stable in DONE.
- Undefined: port absent; no checksum logic.

Test Plan:
- ADD R1,R2,#5: cond=E, op=00, funct=101000, rn=2, rd=1, src2=005, last=1 -> one write, addr 0, data E2821005; done=1, cpu_run=1, word_count=1.
- LDR R3,[R0,#4] then B +3: op=01, funct=011001, rn=0, rd=3, src2=004; then op=10, funct=100000, imm24=000003, last; back-to-back -> E5903004@0 and EA000003@1 on consecutive cycles.
- MUL R4,R5,R6: op=00, mul=1, funct=000000, rd=4, rn=0, src2=0x605 -> E0040695.
- op=11 mid-stream between two ADDs -> only 2 writes, at addr 0,1; err_illegal=1; done=1; cpu_run=0.
- ADDR_WIDTH=2, 5 descriptors with no last -> 4 writes at addr 0..3; err_overflow=1; desc_ready=0 after the 4th accept; cpu_run=0.
- Assert reset low during the 2nd write cycle -> imem_we=0 immediately, all outputs 0; a new start reloads from addr 0.
